// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and load/store requesters, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port unified memory: alternating priority,
// fixed-latency sequencing and a registered one-cycle response per transaction.
//   state   | meaning
//   IDLE    | no transaction in flight, grants possible
//   WAIT    | transaction in flight, latency counter running
module mem_port_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_dm_q, last_dm_d;
  logic              win_dm_q, win_dm_d;
  logic              win_we_q, win_we_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_gnt_c, dm_gnt_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      last_dm_q   <= 1'b0;
      win_dm_q    <= 1'b0;
      win_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      win_dm_q    <= win_dm_d;
      win_we_q    <= win_we_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    win_dm_d    = win_dm_q;
    win_we_d    = win_we_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_gnt_c    = 1'b0;
    dm_gnt_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Under contention the side that did not win last time goes first.
        if (bus.if_req && bus.dm_req) begin
          dm_gnt_c = !last_dm_q;
          if_gnt_c = last_dm_q;
        end else begin
          if_gnt_c = bus.if_req;
          dm_gnt_c = bus.dm_req;
        end
        if (if_gnt_c || dm_gnt_c) begin
          state_d   = ST_WAIT;
          cnt_d     = LAT_LOAD;
          last_dm_d = dm_gnt_c;
          win_dm_d  = dm_gnt_c;
          win_we_d  = dm_gnt_c & bus.dm_we;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
          if (win_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = win_we_q ? '0 : bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command outputs are combinational from the requests, so gate them while reset is held.
  assign bus.if_gnt    = if_gnt_c & reset;
  assign bus.dm_gnt    = dm_gnt_c & reset;
  assign bus.mem_en    = (if_gnt_c | dm_gnt_c) & reset;
  assign bus.mem_we    = dm_gnt_c & bus.dm_we & reset;
  assign bus.mem_addr  = !reset   ? '0 :
                         dm_gnt_c ? bus.dm_addr :
                         if_gnt_c ? bus.if_addr : '0;
  assign bus.mem_wdata = (reset && dm_gnt_c) ? bus.dm_wdata : '0;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances with MEM_LAT 1..4, directed stimulus,
// expected commands/responses queued by the stimulus and checked by one monitor.
module tb_mem_port_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          if_req [NI];
  logic [AW-1:0] if_addr [NI];
  logic          dm_req [NI];
  logic          dm_we [NI];
  logic [AW-1:0] dm_addr [NI];
  logic [DW-1:0] dm_wdata [NI];
  logic          if_gnt [NI], dm_gnt [NI], if_rvalid [NI], dm_rvalid [NI];
  logic          mem_en [NI], mem_we [NI], busy [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [DW-1:0] mem_wdata [NI], if_rdata [NI], dm_rdata [NI], mem_rdata [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g + 1)) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
    );
    assign bus.if_req    = if_req[g];
    assign bus.if_addr   = if_addr[g];
    assign bus.dm_req    = dm_req[g];
    assign bus.dm_we     = dm_we[g];
    assign bus.dm_addr   = dm_addr[g];
    assign bus.dm_wdata  = dm_wdata[g];
    assign bus.mem_rdata = mem_rdata[g];
    assign if_gnt[g]     = bus.if_gnt;
    assign dm_gnt[g]     = bus.dm_gnt;
    assign if_rvalid[g]  = bus.if_rvalid;
    assign dm_rvalid[g]  = bus.dm_rvalid;
    assign if_rdata[g]   = bus.if_rdata;
    assign dm_rdata[g]   = bus.dm_rdata;
    assign mem_en[g]     = bus.mem_en;
    assign mem_we[g]     = bus.mem_we;
    assign mem_addr[g]   = bus.mem_addr;
    assign mem_wdata[g]  = bus.mem_wdata;
    assign busy[g]       = bus.busy;
  end

  // Memory model: read data is valid only in the cycle exactly MEM_LAT after the command.
  logic [DW-1:0] rom [NI][1024];
  logic [DW-1:0] wmem [NI][1024];
  bit            wvalid [NI][1024];
  bit            pend [NI];
  int            age [NI];
  logic [9:0]    maddr [NI];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        pend[k] <= 1'b0;
        age[k]  <= 0;
      end else if (mem_en[k]) begin
        pend[k]  <= 1'b1;
        age[k]   <= 1;
        maddr[k] <= mem_addr[k][9:0];
        if (mem_we[k]) begin
          wmem[k][mem_addr[k][9:0]]   <= mem_wdata[k];
          wvalid[k][mem_addr[k][9:0]] <= 1'b1;
        end
      end else if (pend[k]) begin
        age[k] <= age[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      mem_rdata[k] = 32'hBAD0_BAD0;
      if (pend[k] && age[k] == k + 1)
        mem_rdata[k] = wvalid[k][maddr[k]] ? wmem[k][maddr[k]] : rom[k][maddr[k]];
    end
  end

  typedef struct {
    int            cyc;
    bit            side;   // 0 = IF, 1 = DM
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  cmd_t cmd_q [NI][$];
  rsp_t rsp_q [NI][2][$];

  int   n_run = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  task automatic push_cmd(input int k, input int t, input bit side, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_t c;
    c.cyc = t; c.side = side; c.we = we; c.addr = addr; c.wdata = wdata;
    cmd_q[k].push_back(c);
  endtask

  task automatic push_rsp(input int k, input int side, input int t, input logic [DW-1:0] data);
    rsp_t r;
    r.cyc = t; r.data = data;
    rsp_q[k][side].push_back(r);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NI; k++) begin
      if (cmd_q[k].size() != 0) return 1'b0;
      for (int s = 0; s < 2; s++) if (rsp_q[k][s].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the only process that compares and counts.
  int            wait_end [NI];
  cmd_t          mc;
  rsp_t          mr;
  logic          exp_busy, rv;
  logic [DW-1:0] rd;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        n_run++;
        wait_end[k] = -1;
        if (if_gnt[k] !== 1'b0 || dm_gnt[k] !== 1'b0 || mem_en[k] !== 1'b0 || mem_we[k] !== 1'b0 ||
            mem_addr[k] !== '0 || mem_wdata[k] !== '0 || if_rvalid[k] !== 1'b0 ||
            dm_rvalid[k] !== 1'b0 || if_rdata[k] !== '0 || dm_rdata[k] !== '0 || busy[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_outputs inst=%0d cyc=%0d got gnt=%b/%b en=%b we=%b addr=%h wdata=%h rvalid=%b/%b rdata=%h/%h busy=%b, expected all zero",
                   k, cyc, if_gnt[k], dm_gnt[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k],
                   if_rvalid[k], dm_rvalid[k], if_rdata[k], dm_rdata[k], busy[k]);
        end
      end else begin
        exp_busy = (cyc <= wait_end[k]);
        if (exp_busy || busy[k] !== 1'b0) begin
          n_run++;
          if (busy[k] !== exp_busy) begin
            n_fail++;
            $display("FAIL busy inst=%0d cyc=%0d got %b expected %b", k, cyc, busy[k], exp_busy);
          end
        end

        if (cmd_q[k].size() != 0 && cmd_q[k][0].cyc == cyc) begin
          mc = cmd_q[k].pop_front();
          n_run++;
          if (if_gnt[k] !== (mc.side == 1'b0) || dm_gnt[k] !== (mc.side == 1'b1) || mem_en[k] !== 1'b1 ||
              mem_we[k] !== mc.we || mem_addr[k] !== mc.addr || mem_wdata[k] !== mc.wdata) begin
            n_fail++;
            $display("FAIL grant inst=%0d cyc=%0d got if_gnt=%b dm_gnt=%b en=%b we=%b addr=%h wdata=%h expected side=%0d en=1 we=%b addr=%h wdata=%h",
                     k, cyc, if_gnt[k], dm_gnt[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k],
                     mc.side, mc.we, mc.addr, mc.wdata);
          end
          wait_end[k] = cyc + k + 1;
        end else if (if_gnt[k] !== 1'b0 || dm_gnt[k] !== 1'b0 || mem_en[k] !== 1'b0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_grant inst=%0d cyc=%0d got if_gnt=%b dm_gnt=%b en=%b expected none",
                   k, cyc, if_gnt[k], dm_gnt[k], mem_en[k]);
        end

        for (int s = 0; s < 2; s++) begin
          rv = (s == 0) ? if_rvalid[k] : dm_rvalid[k];
          rd = (s == 0) ? if_rdata[k] : dm_rdata[k];
          if (rsp_q[k][s].size() != 0 && rsp_q[k][s][0].cyc == cyc) begin
            mr = rsp_q[k][s].pop_front();
            n_run++;
            if (rv !== 1'b1 || rd !== mr.data) begin
              n_fail++;
              $display("FAIL response inst=%0d side=%0d cyc=%0d got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                       k, s, cyc, rv, rd, mr.data);
            end
          end else if (rv !== 1'b0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_rvalid inst=%0d side=%0d cyc=%0d got rvalid=%b expected 0", k, s, cyc, rv);
          end
        end
      end
    end

    if (done) begin
      for (int k = 0; k < NI; k++) begin
        n_run++;
        if (cmd_q[k].size() != 0 || rsp_q[k][0].size() != 0 || rsp_q[k][1].size() != 0) begin
          n_fail++;
          $display("FAIL leftover inst=%0d got pending cmd=%0d if_rsp=%0d dm_rsp=%0d expected 0/0/0",
                   k, cmd_q[k].size(), rsp_q[k][0].size(), rsp_q[k][1].size());
        end
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end
  end

  initial begin
    int t;
    int r;
    for (int k = 0; k < NI; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
    end
    rom[0][10'h010] = 32'h0050_0093;
    rom[0][10'h020] = 32'h1111_2222;
    rom[0][10'h040] = 32'h3333_4444;
    rom[2][10'h077] = 32'h7777_7777;
    rom[2][10'h078] = 32'h7878_7878;
    rom[2][10'h079] = 32'h7979_7979;
    rom[3][10'h055] = 32'hA5A5_0055;
    rom[3][10'h066] = 32'h5A5A_0066;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single fetch, MEM_LAT=1
    tick(); t = cyc;
    if_req[0] = 1'b1; if_addr[0] = 20'h00010;
    push_cmd(0, t, 1'b0, 1'b0, 20'h00010, '0);
    push_rsp(0, 0, t + 2, 32'h0050_0093);
    tick(); if_req[0] = 1'b0;
    repeat (3) tick();

    // Store then load, MEM_LAT=2; the load is granted in the store's rvalid cycle
    tick(); t = cyc;
    dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 20'h003FF; dm_wdata[1] = 32'hDEAD_BEEF;
    push_cmd(1, t, 1'b1, 1'b1, 20'h003FF, 32'hDEAD_BEEF);
    push_rsp(1, 1, t + 3, 32'h0);
    tick(); dm_req[1] = 1'b0; dm_we[1] = 1'b0; dm_wdata[1] = '0;
    tick(); tick();
    dm_req[1] = 1'b1;
    push_cmd(1, t + 3, 1'b1, 1'b0, 20'h003FF, '0);
    push_rsp(1, 1, t + 6, 32'hDEAD_BEEF);
    tick(); dm_req[1] = 1'b0;
    repeat (4) tick();

    // Contention with both requests held, MEM_LAT=1: DM, IF, DM, IF
    tick(); t = cyc;
    if_req[0] = 1'b1; if_addr[0] = 20'h00020;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 20'h00040; dm_wdata[0] = '0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        push_cmd(0, t + 2 * i, 1'b1, 1'b0, 20'h00040, '0);
        push_rsp(0, 1, t + 2 * i + 2, 32'h3333_4444);
      end else begin
        push_cmd(0, t + 2 * i, 1'b0, 1'b0, 20'h00020, '0);
        push_rsp(0, 0, t + 2 * i + 2, 32'h1111_2222);
      end
    end
    repeat (7) tick();
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    repeat (3) tick();

    // Request arriving during WAIT, MEM_LAT=4: granted with the fetch's rvalid
    tick(); t = cyc;
    if_req[3] = 1'b1; if_addr[3] = 20'h00055;
    push_cmd(3, t, 1'b0, 1'b0, 20'h00055, '0);
    push_rsp(3, 0, t + 5, 32'hA5A5_0055);
    tick();
    if_req[3] = 1'b0;
    dm_req[3] = 1'b1; dm_we[3] = 1'b0; dm_addr[3] = 20'h00066; dm_wdata[3] = '0;
    push_cmd(3, t + 5, 1'b1, 1'b0, 20'h00066, '0);
    push_rsp(3, 1, t + 10, 32'h5A5A_0066);
    repeat (5) tick();
    dm_req[3] = 1'b0;
    repeat (6) tick();

    // Reset mid-WAIT, MEM_LAT=3: transaction dropped, last_gnt back to IF
    tick(); t = cyc;
    dm_req[2] = 1'b1; dm_we[2] = 1'b0; dm_addr[2] = 20'h00077; dm_wdata[2] = '0;
    push_cmd(2, t, 1'b1, 1'b0, 20'h00077, '0);
    tick(); dm_req[2] = 1'b0;
    tick();
    rst_n = 1'b0;
    if_req[2] = 1'b1; if_addr[2] = 20'h00078;
    dm_req[2] = 1'b1; dm_addr[2] = 20'h00079;
    tick(); tick();
    if_req[2] = 1'b0; dm_req[2] = 1'b0;
    rst_n = 1'b1;
    tick(); r = cyc;
    if_req[2] = 1'b1; dm_req[2] = 1'b1;
    push_cmd(2, r, 1'b1, 1'b0, 20'h00079, '0);
    push_rsp(2, 1, r + 4, 32'h7979_7979);
    push_cmd(2, r + 4, 1'b0, 1'b0, 20'h00078, '0);
    push_rsp(2, 0, r + 8, 32'h7878_7878);
    repeat (5) tick();
    if_req[2] = 1'b0; dm_req[2] = 1'b0;
    repeat (10) tick();

    for (int i = 0; i < 60 && !all_empty(); i++) tick();
    repeat (5) tick();
    done = 1'b1;
    repeat (4) tick();
    $display("FAIL monitor did not finish the run");
    $fatal(1);
  end

endmodule
